// File: rtl/prng_pkg.sv
// Shared types and constants for the XNOR-LFSR PRNG controller.
package prng_pkg;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_READY  = 2'd2
   } state_e;

   localparam int SEED_WORDS = 6;
   localparam int LFSR_W     = 168;
   localparam int RND_W      = 3;
   localparam int WORD_W     = 32;
   localparam int LAST_BITS  = LFSR_W - WORD_W * (SEED_WORDS - 1);

   // Bits of seed word idx that actually land in the LFSR.
   function automatic logic [WORD_W-1:0] seed_mask(input logic [2:0] idx);
      seed_mask = '1;
      if (int'(idx) == SEED_WORDS - 1) begin
         seed_mask = {{(WORD_W - LAST_BITS){1'b0}}, {LAST_BITS{1'b1}}};
      end
   endfunction

endpackage

// File: rtl/prng_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   gnt_idx_o
);

   logic          found;
   logic [PW-1:0] k;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      k         = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = PW'((int'(ptr_i) + i) % NREQ);
         if (!found && req_i[k]) begin
            found     = 1'b1;
            gnt_o[k]  = 1'b1;
            gnt_idx_o = k;
         end
      end
   end

endmodule

// File: rtl/prng_sched.sv
// Seeding, warm-up and round-robin sharing controller for the
// 168-bit XNOR-LFSR PRNG datapath.
module prng_sched
   import prng_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int WARMUP_CYC = 168
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              cfg_we_i,
   input  logic [31:0]       cfg_dat_i,
   input  logic              cfg_restart_i,
   input  logic [NREQ-1:0]   req_i,
   output logic [NREQ-1:0]   vld_o,
   output logic [RND_W-1:0]  rnd_o,
   output logic              seed_wr_o,
   output logic [2:0]        seed_idx_o,
   output logic [31:0]       seed_dat_o,
   output logic              step_o,
   input  logic [RND_W-1:0]  rnd_i,
   output logic              ready_o,
   output logic              seed_err_o,
   output logic [1:0]        state_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WARMUP_CYC - 1);
   localparam logic [2:0]    IDX_LAST = 3'(SEED_WORDS - 1);

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic              and_q, and_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   vld_q, vld_d;
   logic [RND_W-1:0]  rnd_q, rnd_d;

   logic [NREQ-1:0]   gnt;
   logic [PW-1:0]     gnt_idx;
   logic              seed_wr;
   logic              step;
   logic              word_ones;
   logic              all_ones;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // An all-ones seed is the XNOR lock-up state and must be rejected.
   assign word_ones = &(cfg_dat_i | ~seed_mask(idx_q));
   assign all_ones  = and_q & word_ones;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      and_d   = and_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ptr_d   = ptr_q;
      vld_d   = '0;
      rnd_d   = rnd_q;
      seed_wr = 1'b0;
      step    = 1'b0;

      unique case (state_q)
         ST_SEED: begin
            if (cfg_we_i) begin
               seed_wr = 1'b1;
               err_d   = 1'b0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  and_d = 1'b1;
                  if (all_ones) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_WARMUP;
                     cnt_d   = '0;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  and_d = all_ones;
               end
            end
         end
         ST_WARMUP: begin
            step = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (|req_i) begin
               step  = 1'b1;
               vld_d = gnt;
               rnd_d = rnd_i;
               ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end
         end
         default: begin
            state_d = ST_SEED;
            idx_d   = '0;
         end
      endcase

      // A grant issued in the restart cycle is dropped.
      if (cfg_restart_i) begin
         state_d = ST_SEED;
         idx_d   = '0;
         and_d   = 1'b1;
         cnt_d   = '0;
         err_d   = err_q;
         ptr_d   = ptr_q;
         vld_d   = '0;
         rnd_d   = rnd_q;
         seed_wr = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_SEED;
         idx_q   <= '0;
         and_q   <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ptr_q   <= '0;
         vld_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         and_q   <= and_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
         rnd_q   <= rnd_d;
      end
   end

   assign seed_wr_o  = seed_wr;
   assign seed_idx_o = idx_q;
   assign seed_dat_o = seed_wr ? cfg_dat_i : '0;
   assign step_o     = step;
   assign vld_o      = vld_q;
   assign rnd_o      = rnd_q;
   assign ready_o    = (state_q == ST_READY);
   assign seed_err_o = err_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_prng_sched.sv
// Directed bench for prng_sched: seeding, lock-up rejection, warm-up length,
// round-robin grants via a scoreboard, restart and asynchronous reset.
module tb_prng_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [31:0] cfg_dat = '0;
   logic        cfg_restart = 1'b0;
   logic [3:0]  req_i = '0;
   logic [3:0]  vld_o;
   logic [2:0]  rnd_o;
   logic        seed_wr_o;
   logic [2:0]  seed_idx_o;
   logic [31:0] seed_dat_o;
   logic        step_o;
   logic [2:0]  rnd_i = '0;
   logic        ready_o;
   logic        seed_err_o;
   logic [1:0]  state_o;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [2:0] r;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] last_rnd = '0;
   logic [3:0] rr_exp [8];

   always #5 clk = ~clk;

   prng_sched dut (
      .wb_clk_i      (clk),
      .wb_rst_n      (rst_n),
      .cfg_we_i      (cfg_we),
      .cfg_dat_i     (cfg_dat),
      .cfg_restart_i (cfg_restart),
      .req_i         (req_i),
      .vld_o         (vld_o),
      .rnd_o         (rnd_o),
      .seed_wr_o     (seed_wr_o),
      .seed_idx_o    (seed_idx_o),
      .seed_dat_o    (seed_dat_o),
      .step_o        (step_o),
      .rnd_i         (rnd_i),
      .ready_o       (ready_o),
      .seed_err_o    (seed_err_o),
      .state_o       (state_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic seed_word(input logic [31:0] d, input logic [2:0] idx);
      cfg_we  = 1'b1;
      cfg_dat = d;
      #1;
      chk("seed_wr", seed_wr_o, 1);
      chk("seed_idx", seed_idx_o, idx);
      chk("seed_dat", seed_dat_o, d);
      chk("seed_nostep", step_o, 0);
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
      cfg_dat = '0;
   endtask

   task automatic seed_good();
      for (int i = 0; i < 6; i++) seed_word(32'(i + 1), 3'(i));
      chk("to_warmup", state_o, 1);
   endtask

   task automatic cyc(input logic [3:0] req, input logic [3:0] g);
      exp_t       e;
      logic [2:0] r;
      r     = 3'($urandom_range(0, 7));
      req_i = req;
      rnd_i = r;
      #1;
      chk("step", step_o, |req);
      if (|req) begin
         e.g = g;
         e.r = r;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("vld", vld_o, e.g);
         chk("rnd", rnd_o, e.r);
         last_rnd = e.r;
      end else begin
         chk("vld_idle", vld_o, 0);
         chk("rnd_hold", rnd_o, last_rnd);
      end
   endtask

   task automatic run_warm(input int exp_steps, input logic [3:0] req);
      int   steps;
      logic bad;
      steps = 0;
      bad   = 1'b0;
      req_i = req;
      for (int c = 0; c < 400; c++) begin
         if (state_o != 2'd1) break;
         rnd_i = 3'($urandom_range(0, 7));
         #1;
         if (step_o) steps++;
         if (vld_o != 4'b0) bad = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("warm_steps", 64'(steps), 64'(exp_steps));
      chk("warm_state", state_o, 2);
      chk("warm_ready", ready_o, 1);
      chk("warm_novld", bad, 0);
   endtask

   initial begin
      int   steps;
      logic bad;
      rr_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_vld", vld_o, 0);
      chk("rst_step", step_o, 0);
      chk("rst_err", seed_err_o, 0);
      chk("rst_rnd", rnd_o, 0);
      chk("rst_seed_wr", seed_wr_o, 0);
      chk("rst_seed_idx", seed_idx_o, 0);
      chk("rst_seed_dat", seed_dat_o, 0);
      rst_n = 1'b1;

      // lock-up seed rejected
      for (int i = 0; i < 6; i++) seed_word(32'hFFFF_FFFF, 3'(i));
      chk("ones_err", seed_err_o, 1);
      chk("ones_state", state_o, 0);
      cyc(4'b0000, 4'b0000);

      // upper bits of the last word do not count
      seed_word(32'hFFFF_FFFF, 3'd0);
      chk("err_clear", seed_err_o, 0);
      for (int i = 1; i < 5; i++) seed_word(32'hFFFF_FFFF, 3'(i));
      seed_word(32'h0000_00FF, 3'd5);
      chk("ones8_err", seed_err_o, 1);
      chk("ones8_state", state_o, 0);

      seed_good();
      chk("good_err", seed_err_o, 0);
      run_warm(168, 4'b0010);

      // request held through warm-up is served first
      cyc(4'b0010, 4'b0010);
      for (int i = 0; i < 8; i++) cyc(4'b1111, rr_exp[i]);
      cyc(4'b0000, 4'b0000);
      repeat (4) cyc(4'b0100, 4'b0100);
      cyc(4'b1111, 4'b1000);
      cyc(4'b1111, 4'b0001);
      cyc(4'b0000, 4'b0000);

      // seed writes ignored outside SEED
      cfg_we  = 1'b1;
      cfg_dat = 32'h1234_5678;
      #1;
      chk("ready_we_wr", seed_wr_o, 0);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk("ready_we_state", state_o, 2);

      // restart with a grant in the same cycle
      req_i       = 4'b1111;
      rnd_i       = 3'd5;
      cfg_restart = 1'b1;
      #1;
      chk("rs_step", step_o, 1);
      @(posedge clk);
      #1;
      cfg_restart = 1'b0;
      req_i       = 4'b0000;
      chk("rs_vld", vld_o, 0);
      chk("rs_state", state_o, 0);
      chk("rs_rnd", rnd_o, last_rnd);

      // restart part-way through warm-up
      seed_good();
      steps = 0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (step_o) steps++;
         @(posedge clk);
         #1;
      end
      chk("part_steps", 64'(steps), 50);
      cfg_restart = 1'b1;
      @(posedge clk);
      #1;
      cfg_restart = 1'b0;
      chk("wrs_state", state_o, 0);
      chk("wrs_step", step_o, 0);
      chk("wrs_ready", ready_o, 0);
      seed_good();
      run_warm(168, 4'b0000);

      // asynchronous reset mid-READY
      cyc(4'b0001, 4'b0001);
      cyc(4'b1111, 4'b0010);
      req_i = 4'b1111;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_vld", vld_o, 0);
      chk("ar_step", step_o, 0);
      chk("ar_ready", ready_o, 0);
      chk("ar_state", state_o, 0);
      sb.delete();
      last_rnd = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (step_o || vld_o != 4'b0) bad = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("ar_quiet", bad, 0);
      seed_good();
      run_warm(168, 4'b1111);
      cyc(4'b1111, 4'b0001);
      cyc(4'b1111, 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
